// File: rtl/led_scan_pkg.sv
// led_scan_pkg
// Shared constants and types for the multiplexed LED-matrix driver.
// Holds the default geometry and timing of the board's LED array. The
// driver modules take these as parameter defaults and derive their own
// counter widths from whatever values they are actually built with.
// No ports (package).
package led_scan_pkg;

    localparam int DEF_ROWS         = 20;
    localparam int DEF_COLS         = 20;
    localparam int DEF_DWELL_CYCLES = 6250;
    localparam int DEF_BLANK_CYCLES = 16;
    localparam int DEF_PWM_BITS     = 4;

    localparam int ROW_W   = $clog2(DEF_ROWS);
    localparam int DWELL_W = $clog2(DEF_DWELL_CYCLES);

    // One row of the frame store at the default column count; 1 = LED lit.
    typedef logic [DEF_COLS-1:0] row_bits_t;

endpackage

// File: rtl/led_scan_timer.sv
// led_scan_timer
// Scan timing for the LED-matrix driver: dwell, row and PWM counters.
// Ports:
//   CLK, RST_N  clock and synchronous active-low reset
//   enable      1 = counters run; 0 = counters held at 0
//   bright      global brightness, all-ones = always on
//   row_cnt     row currently being scanned
//   drive_on    1 = the selected row may be driven this cycle
//   boundary    1 in the last cycle of the last row of a frame
module led_scan_timer
    import led_scan_pkg::*;
#(
    parameter int ROWS         = DEF_ROWS,
    parameter int DWELL_CYCLES = DEF_DWELL_CYCLES,
    parameter int BLANK_CYCLES = DEF_BLANK_CYCLES,
    parameter int PWM_BITS     = DEF_PWM_BITS
) (
    input  logic                      CLK,
    input  logic                      RST_N,
    input  logic                      enable,
    input  logic [PWM_BITS-1:0]       bright,
    output logic [$clog2(ROWS)-1:0]   row_cnt,
    output logic                      drive_on,
    output logic                      boundary
);

    localparam int ROW_BITS   = $clog2(ROWS);
    localparam int DWELL_BITS = $clog2(DWELL_CYCLES);

    logic [DWELL_BITS-1:0] dwell_cnt;
    logic [PWM_BITS-1:0]   pwm_cnt;
    logic                  dwell_last;
    logic                  row_last;
    logic                  pwm_pass;

    assign dwell_last = (dwell_cnt == DWELL_BITS'(DWELL_CYCLES - 1));
    assign row_last   = (row_cnt == ROW_BITS'(ROWS - 1));

    // All-ones brightness must be fully on, which pwm_cnt < bright alone
    // cannot express since the counter reaches the all-ones value too.
    assign pwm_pass = (bright == '1) || (pwm_cnt < bright);

    // The opening cycles of every dwell stay dark so the previous row's
    // charge has drained before the next row is lit (anti-ghosting).
    assign drive_on = enable && (dwell_cnt >= DWELL_BITS'(BLANK_CYCLES)) && pwm_pass;

    assign boundary = enable && row_last && dwell_last;

    // Disabling parks every counter at zero so a re-enable always restarts
    // the scan at row 0, dwell 0.
    always_ff @(posedge CLK) begin
        if (!RST_N || !enable) begin
            dwell_cnt <= '0;
            row_cnt   <= '0;
            pwm_cnt   <= '0;
        end else begin
            pwm_cnt <= pwm_cnt + 1'b1;
            if (dwell_last) begin
                dwell_cnt <= '0;
                row_cnt   <= row_last ? '0 : row_cnt + 1'b1;
            end else begin
                dwell_cnt <= dwell_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/led_matrix_scan.sv
// led_matrix_scan
// Multiplexed LED-matrix driver with a double-buffered frame store,
// per-row blanking and global PWM brightness.
// Ports:
//   CLK, RST_N   clock and synchronous active-low reset
//   enable       1 = scan running
//   bright       global brightness, all-ones = full on
//   wr_en        write one row of the back buffer
//   wr_row       row index for the write (out-of-range rows ignored)
//   wr_data      row contents, 1 = LED lit
//   commit       request back->front swap at the next frame boundary
//   swap_pend    a swap is requested but not yet done
//   frame_done   1-cycle pulse after each frame boundary
//   led_anode    active-high row select, one-hot or zero
//   led_cathode  active-low column sinks
module led_matrix_scan
    import led_scan_pkg::*;
#(
    parameter int ROWS         = DEF_ROWS,
    parameter int COLS         = DEF_COLS,
    parameter int DWELL_CYCLES = DEF_DWELL_CYCLES,
    parameter int BLANK_CYCLES = DEF_BLANK_CYCLES,
    parameter int PWM_BITS     = DEF_PWM_BITS
) (
    input  logic                      CLK,
    input  logic                      RST_N,
    input  logic                      enable,
    input  logic [PWM_BITS-1:0]       bright,
    input  logic                      wr_en,
    input  logic [$clog2(ROWS)-1:0]   wr_row,
    input  logic [COLS-1:0]           wr_data,
    input  logic                      commit,
    output logic                      swap_pend,
    output logic                      frame_done,
    output logic [ROWS-1:0]           led_anode,
    output logic [COLS-1:0]           led_cathode
);

    localparam int ROW_BITS = $clog2(ROWS);

    logic [ROW_BITS-1:0] row_cnt;
    logic                drive_on;
    logic                boundary;
    logic                swap_now;
    logic [COLS-1:0]     front_buf [ROWS];
    logic [COLS-1:0]     back_buf  [ROWS];

    led_scan_timer #(
        .ROWS         (ROWS),
        .DWELL_CYCLES (DWELL_CYCLES),
        .BLANK_CYCLES (BLANK_CYCLES),
        .PWM_BITS     (PWM_BITS)
    ) u_timer (
        .CLK      (CLK),
        .RST_N    (RST_N),
        .enable   (enable),
        .bright   (bright),
        .row_cnt  (row_cnt),
        .drive_on (drive_on),
        .boundary (boundary)
    );

    // A pending swap also fires on any disabled edge, so stopping the scan
    // never leaves a committed frame stranded in the back buffer.
    assign swap_now = swap_pend && (boundary || !enable);

    // Frame store and swap bookkeeping. The swap reads back_buf before this
    // edge's write lands, so a same-cycle write stays in the back buffer
    // only. A commit on the swap edge re-arms swap_pend for the next frame.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            for (int i = 0; i < ROWS; i++) begin
                front_buf[i] <= '0;
                back_buf[i]  <= '0;
            end
            swap_pend  <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= boundary;
            if (swap_now) begin
                for (int i = 0; i < ROWS; i++) begin
                    front_buf[i] <= back_buf[i];
                end
            end
            if (wr_en && (32'(wr_row) < ROWS)) begin
                back_buf[wr_row] <= wr_data;
            end
            if (commit) begin
                swap_pend <= 1'b1;
            end else if (swap_now) begin
                swap_pend <= 1'b0;
            end
        end
    end

    // Anode and cathode come from one register stage fed by the same
    // row_cnt, so a row is never lit with another row's column pattern.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            led_anode   <= '0;
            led_cathode <= '1;
        end else if (drive_on) begin
            led_anode   <= ROWS'(1) << row_cnt;
            led_cathode <= ~front_buf[row_cnt];
        end else begin
            led_anode   <= '0;
            led_cathode <= '1;
        end
    end

endmodule

// File: tb/tb_led_matrix_scan.sv
// tb_led_matrix_scan
// Drives led_matrix_scan (4 rows x 8 columns, 10-cycle dwell, 2 blank
// cycles, 2-bit PWM) through directed scenarios and a randomized phase,
// comparing every output on every cycle against a reference model that
// derives scan position from a single elapsed-cycle count.
module tb_led_matrix_scan;

    localparam int R = 4;
    localparam int C = 8;
    localparam int D = 10;
    localparam int B = 2;
    localparam int P = 2;
    localparam int FRAME = R * D;

    logic         CLK = 1'b0;
    logic         RST_N;
    logic         enable;
    logic [P-1:0] bright;
    logic         wr_en;
    logic [1:0]   wr_row;
    logic [C-1:0] wr_data;
    logic         commit;
    logic         swap_pend;
    logic         frame_done;
    logic [R-1:0] led_anode;
    logic [C-1:0] led_cathode;

    int total = 0;
    int bad   = 0;

    // Reference model state: elapsed enabled cycles since scan start,
    // the two frame buffers, and the pending-swap flag.
    int           k = 0;
    bit           m_swap = 1'b0;
    logic [C-1:0] m_front [R];
    logic [C-1:0] m_back  [R];

    logic         cur_en = 1'b1;
    logic [P-1:0] cur_br = 2'd3;

    always #5 CLK = ~CLK;

    led_matrix_scan #(
        .ROWS         (R),
        .COLS         (C),
        .DWELL_CYCLES (D),
        .BLANK_CYCLES (B),
        .PWM_BITS     (P)
    ) dut (
        .CLK         (CLK),
        .RST_N       (RST_N),
        .enable      (enable),
        .bright      (bright),
        .wr_en       (wr_en),
        .wr_row      (wr_row),
        .wr_data     (wr_data),
        .commit      (commit),
        .swap_pend   (swap_pend),
        .frame_done  (frame_done),
        .led_anode   (led_anode),
        .led_cathode (led_cathode)
    );

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        total++;
        if (observed !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %0h, wanted %0h (t=%0t)", tag, observed, expected, $time);
        end
    endtask

    // One clock: drive inputs, predict outputs, advance, compare.
    task automatic applyStimulus(input logic rst_n_i, input logic en_i,
                                 input logic [P-1:0] br_i, input logic we_i,
                                 input logic [1:0] row_i, input logic [C-1:0] data_i,
                                 input logic cm_i);
        int           row;
        int           dwell;
        int           pwm;
        bit           on;
        bit           at_boundary;
        bit           swap;
        logic [R-1:0] e_an;
        logic [C-1:0] e_ca;
        bit           e_fd;

        RST_N   = rst_n_i;
        enable  = en_i;
        bright  = br_i;
        wr_en   = we_i;
        wr_row  = row_i;
        wr_data = data_i;
        commit  = cm_i;

        if (!rst_n_i) begin
            e_an   = '0;
            e_ca   = '1;
            e_fd   = 1'b0;
            m_swap = 1'b0;
            k      = 0;
            for (int i = 0; i < R; i++) begin
                m_front[i] = '0;
                m_back[i]  = '0;
            end
        end else begin
            row   = (k / D) % R;
            dwell = k % D;
            pwm   = k % (1 << P);
            on    = en_i && (dwell >= B) && ((br_i == 2'd3) || (pwm < int'(br_i)));
            e_an  = on ? R'(1 << row) : '0;
            e_ca  = on ? ~m_front[row] : '1;
            at_boundary = en_i && ((k % FRAME) == FRAME - 1);
            e_fd  = at_boundary;
            swap  = m_swap && (at_boundary || !en_i);
            if (swap) begin
                for (int i = 0; i < R; i++) m_front[i] = m_back[i];
            end
            if (we_i) m_back[row_i] = data_i;
            if (cm_i) m_swap = 1'b1;
            else if (swap) m_swap = 1'b0;
            k = en_i ? k + 1 : 0;
        end

        @(posedge CLK);
        #1;
        checkOutput("led_anode",   32'(led_anode),   32'(e_an));
        checkOutput("led_cathode", 32'(led_cathode), 32'(e_ca));
        checkOutput("frame_done",  32'(frame_done),  32'(e_fd));
        checkOutput("swap_pend",   32'(swap_pend),   32'(m_swap));
    endtask

    task automatic runIdle(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b1, cur_en, cur_br, 1'b0, 2'd0, 8'h00, 1'b0);
    endtask

    // Advance until the next cycle to be driven sits at the given frame phase.
    task automatic runUntil(input int phase);
        for (int i = 0; i < FRAME + 2; i++) begin
            if ((k % FRAME) == phase) return;
            runIdle(1);
        end
        checkOutput("run_until_bound", 32'(k % FRAME), 32'(phase));
    endtask

    task automatic writeRow(input logic [1:0] r, input logic [C-1:0] d);
        applyStimulus(1'b1, cur_en, cur_br, 1'b1, r, d, 1'b0);
    endtask

    task automatic doCommit();
        applyStimulus(1'b1, cur_en, cur_br, 1'b0, 2'd0, 8'h00, 1'b1);
    endtask

    initial begin
        // Scenario 1: reset, full brightness, blank frame store.
        for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b1, 2'd3, 1'b0, 2'd0, 8'h00, 1'b0);
        runIdle(90);

        // Scenario 2: load a diagonal and commit; shows up next frame.
        writeRow(2'd0, 8'h01);
        writeRow(2'd1, 8'h02);
        writeRow(2'd2, 8'h04);
        writeRow(2'd3, 8'h08);
        doCommit();
        checkOutput("s2_pending", 32'(swap_pend), 32'd1);
        runIdle(100);

        // Scenario 3: reduced and zero brightness.
        cur_br = 2'd1;
        runIdle(50);
        cur_br = 2'd0;
        runIdle(50);
        cur_br = 2'd3;

        // Scenario 4: write + commit exactly in the boundary cycle.
        runUntil(FRAME - 1);
        applyStimulus(1'b1, 1'b1, cur_br, 1'b1, 2'd0, 8'hAA, 1'b1);
        checkOutput("s4_pend_kept", 32'(swap_pend), 32'd1);
        runIdle(90);

        // Scenario 5: drop enable mid-row-2 with a swap pending.
        writeRow(2'd1, 8'h55);
        runUntil(0);
        doCommit();
        runUntil(25);
        cur_en = 1'b0;
        runIdle(1);
        checkOutput("s5_swap_done", 32'(swap_pend), 32'd0);
        checkOutput("s5_anode_off", 32'(led_anode), 32'd0);
        runIdle(2);
        cur_en = 1'b1;
        runIdle(50);

        // Scenario 6: reset mid-frame clears everything.
        runUntil(15);
        applyStimulus(1'b0, 1'b1, cur_br, 1'b0, 2'd0, 8'h00, 1'b0);
        writeRow(2'd2, 8'h3C);
        runIdle(45);

        // Randomized traffic.
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 59) == 0) cur_en = ~cur_en;
            if ($urandom_range(0, 99) == 0) cur_br = P'($urandom_range(0, 3));
            applyStimulus(($urandom_range(0, 299) != 0), cur_en, cur_br,
                          ($urandom_range(0, 3) == 0), 2'($urandom_range(0, 3)),
                          8'($urandom), ($urandom_range(0, 19) == 0));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
